// File: rtl/core_bus_router.sv
// Data-side router: decodes one CPU access onto one of N_PORTS windows, stalls the
// CPU until that port completes, and reports decode-miss, timeout and ren&wen faults.
module core_bus_router #(
    parameter int                        N_PORTS        = 2,
    parameter int                        ADDR_W         = 64,
    parameter int                        DATA_W         = 64,
    parameter logic [N_PORTS*ADDR_W-1:0] REGION_BASE    = {64'h1000_0000, 64'h8000_0000},
    parameter logic [N_PORTS*ADDR_W-1:0] REGION_MASK    = {64'hFFFF_FFFF_F000_0000,
                                                           64'hFFFF_FFFF_8000_0000},
    parameter int                        TIMEOUT_CYCLES = 1024,
    parameter int                        CNT_W          = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [ADDR_W-1:0]           address_cpu,
    input  logic                        ren_cpu,
    input  logic                        wen_cpu,
    input  logic [DATA_W-1:0]           wdata_cpu,
    input  logic [DATA_W/8-1:0]         wmask_cpu,
    output logic [DATA_W-1:0]           rdata_cpu,
    output logic                        mem_stall,
    output logic                        access_fault,
    output logic [1:0]                  fault_cause,
    output logic [ADDR_W-1:0]           fault_addr,
    output logic [N_PORTS*ADDR_W-1:0]   address_port,
    output logic [N_PORTS-1:0]          ren_port,
    output logic [N_PORTS-1:0]          wen_port,
    output logic [DATA_W/8-1:0]         wmask_port,
    output logic [DATA_W-1:0]           wdata_port,
    input  logic [N_PORTS*DATA_W-1:0]   rdata_port,
    input  logic [N_PORTS-1:0]          valid_port,
    output logic [N_PORTS*CNT_W-1:0]    txn_count
);

    localparam int MASK_W = DATA_W / 8;
    localparam int SEL_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The watchdog holds the number of BUSY cycles already spent, so the cycle in
    // which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_MISS    = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_BOTH    = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                write_q, write_d;
    logic                fault_q, fault_d;
    logic [1:0]          cause_q, cause_d;
    logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [CNT_W-1:0]    txn_q [N_PORTS];
    logic [CNT_W-1:0]    txn_d [N_PORTS];

    logic                req;
    logic                hit;
    logic [SEL_W-1:0]    hit_idx;
    logic                wd_expired;

    assign req = ren_cpu | wen_cpu;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if ((address_cpu & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        write_d      = write_q;
        fault_d      = fault_q;
        cause_d      = cause_q;
        fault_addr_d = fault_addr_q;
        rdata_d      = rdata_q;
        wd_d         = wd_q;
        txn_d        = txn_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = address_cpu;
                    wdata_d = wdata_cpu;
                    wmask_d = wmask_cpu;
                    write_d = wen_cpu;
                    wd_d    = '0;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                    if (ren_cpu && wen_cpu) begin
                        state_d      = DONE;
                        fault_d      = 1'b1;
                        cause_d      = CAUSE_BOTH;
                        fault_addr_d = address_cpu;
                        rdata_d      = '0;
                    end else if (!hit) begin
                        state_d      = DONE;
                        fault_d      = 1'b1;
                        cause_d      = CAUSE_MISS;
                        fault_addr_d = address_cpu;
                        rdata_d      = '0;
                    end else begin
                        state_d = BUSY;
                        sel_d   = hit_idx;
                    end
                end
            end
            BUSY: begin
                // A completion in the expiry cycle takes priority over the abort.
                if (valid_port[sel_q]) begin
                    state_d = DONE;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                    if (!write_q) begin
                        rdata_d = rdata_port[int'(sel_q)*DATA_W +: DATA_W];
                    end
                    txn_d[sel_q] = txn_q[sel_q] + CNT_W'(1);
                end else if (wd_expired) begin
                    state_d      = DONE;
                    fault_d      = 1'b1;
                    cause_d      = CAUSE_TIMEOUT;
                    fault_addr_d = addr_q;
                    rdata_d      = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                fault_d = 1'b0;
                cause_d = CAUSE_NONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            write_q      <= 1'b0;
            fault_q      <= 1'b0;
            cause_q      <= CAUSE_NONE;
            fault_addr_q <= '0;
            rdata_q      <= '0;
            wd_q         <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                txn_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            write_q      <= write_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
            fault_addr_q <= fault_addr_d;
            rdata_q      <= rdata_d;
            wd_q         <= wd_d;
            txn_q        <= txn_d;
        end
    end

    // Port strobes come straight from registered state so reset removes them at once.
    always_comb begin
        ren_port     = '0;
        wen_port     = '0;
        address_port = '0;
        if (state_q == BUSY) begin
            ren_port[sel_q] = ~write_q;
            wen_port[sel_q] = write_q;
            address_port[int'(sel_q)*ADDR_W +: ADDR_W] = addr_q;
        end
    end

    assign wdata_port   = wdata_q;
    assign wmask_port   = wmask_q;
    assign rdata_cpu    = rdata_q;
    assign fault_addr   = fault_addr_q;
    assign mem_stall    = req & (state_q != DONE);
    assign access_fault = (state_q == DONE) & fault_q;
    assign fault_cause  = access_fault ? cause_q : CAUSE_NONE;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_txn
        assign txn_count[g*CNT_W +: CNT_W] = txn_q[g];
    end

endmodule

// File: tb/tb_core_bus_router.sv
// Directed bench for core_bus_router: a transaction-level reference model checked on
// every falling edge, plus hand-computed expectations for each scenario.
`timescale 1ns/1ps
module tb_core_bus_router;

    localparam int NP = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int TO = 8;
    localparam int CW = 32;
    localparam logic [NP*AW-1:0] BASE = {64'h1000_0000, 64'h8000_0000};
    localparam logic [NP*AW-1:0] MASK = {64'hFFFF_FFFF_F000_0000, 64'hFFFF_FFFF_8000_0000};
    localparam int PH_IDLE   = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_REPORT = 2;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]    address_cpu = '0;
    logic             ren_cpu     = 1'b0;
    logic             wen_cpu     = 1'b0;
    logic [DW-1:0]    wdata_cpu   = '0;
    logic [MW-1:0]    wmask_cpu   = '0;
    logic [DW-1:0]    rdata_cpu;
    logic             mem_stall;
    logic             access_fault;
    logic [1:0]       fault_cause;
    logic [AW-1:0]    fault_addr;
    logic [NP*AW-1:0] address_port;
    logic [NP-1:0]    ren_port;
    logic [NP-1:0]    wen_port;
    logic [MW-1:0]    wmask_port;
    logic [DW-1:0]    wdata_port;
    logic [NP*DW-1:0] rdata_port  = '0;
    logic [NP-1:0]    valid_port  = '0;
    logic [NP*CW-1:0] txn_count;

    core_bus_router #(
        .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .REGION_BASE(BASE), .REGION_MASK(MASK),
        .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .address_cpu(address_cpu), .ren_cpu(ren_cpu), .wen_cpu(wen_cpu),
        .wdata_cpu(wdata_cpu), .wmask_cpu(wmask_cpu), .rdata_cpu(rdata_cpu), .mem_stall(mem_stall),
        .access_fault(access_fault), .fault_cause(fault_cause), .fault_addr(fault_addr),
        .address_port(address_port), .ren_port(ren_port), .wen_port(wen_port),
        .wmask_port(wmask_port), .wdata_port(wdata_port), .rdata_port(rdata_port),
        .valid_port(valid_port), .txn_count(txn_count)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_err  = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_phase;
    int            m_port;
    int            m_waited;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    logic [DW-1:0] m_rdata;
    logic          m_fault;
    logic [1:0]    m_cause;
    logic [AW-1:0] m_faddr;
    logic [CW-1:0] m_txn [NP];

    function automatic int window_of(input logic [AW-1:0] a);
        logic [NP*AW-1:0] bases;
        logic [NP*AW-1:0] masks;
        bases = BASE;
        masks = MASK;
        for (int i = 0; i < NP; i++) begin
            if ((a & masks[i*AW +: AW]) == bases[i*AW +: AW]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase  <= PH_IDLE;
            m_port   <= 0;
            m_waited <= 0;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_wmask  <= '0;
            m_rdata  <= '0;
            m_fault  <= 1'b0;
            m_cause  <= 2'd0;
            m_faddr  <= '0;
            for (int i = 0; i < NP; i++) m_txn[i] <= '0;
        end else if (m_phase == PH_IDLE) begin
            if (ren_cpu || wen_cpu) begin
                m_addr   <= address_cpu;
                m_wdata  <= wdata_cpu;
                m_wmask  <= wmask_cpu;
                m_write  <= wen_cpu;
                m_waited <= 0;
                if (ren_cpu && wen_cpu) begin
                    m_phase <= PH_REPORT;
                    m_fault <= 1'b1;
                    m_cause <= 2'd3;
                    m_rdata <= '0;
                    m_faddr <= address_cpu;
                end else if (window_of(address_cpu) < 0) begin
                    m_phase <= PH_REPORT;
                    m_fault <= 1'b1;
                    m_cause <= 2'd1;
                    m_rdata <= '0;
                    m_faddr <= address_cpu;
                end else begin
                    m_phase <= PH_WAIT;
                    m_fault <= 1'b0;
                    m_port  <= window_of(address_cpu);
                end
            end
        end else if (m_phase == PH_WAIT) begin
            m_waited <= m_waited + 1;
            if (valid_port[m_port]) begin
                m_phase <= PH_REPORT;
                m_fault <= 1'b0;
                if (!m_write) m_rdata <= rdata_port[m_port*DW +: DW];
                m_txn[m_port] <= m_txn[m_port] + 1;
            end else if (TO != 0 && m_waited + 1 == TO) begin
                m_phase <= PH_REPORT;
                m_fault <= 1'b1;
                m_cause <= 2'd2;
                m_rdata <= '0;
                m_faddr <= m_addr;
            end
        end else begin
            m_phase <= PH_IDLE;
            m_fault <= 1'b0;
        end
    end

    logic [NP-1:0]    e_ren;
    logic [NP-1:0]    e_wen;
    logic [NP*AW-1:0] e_addrp;
    logic             e_stall;
    logic             e_fault;
    logic [1:0]       e_cause;
    logic [NP*CW-1:0] e_txn;

    always_comb begin
        e_ren   = '0;
        e_wen   = '0;
        e_addrp = '0;
        if (m_phase == PH_WAIT) begin
            if (m_write) e_wen[m_port] = 1'b1;
            else         e_ren[m_port] = 1'b1;
            e_addrp[m_port*AW +: AW] = m_addr;
        end
        e_stall = (ren_cpu || wen_cpu) && (m_phase != PH_REPORT);
        e_fault = (m_phase == PH_REPORT) && m_fault;
        e_cause = e_fault ? m_cause : 2'd0;
        e_txn   = '0;
        for (int i = 0; i < NP; i++) e_txn[i*CW +: CW] = m_txn[i];
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("mem_stall",    256'(mem_stall),    256'(e_stall));
            check("ren_port",     256'(ren_port),     256'(e_ren));
            check("wen_port",     256'(wen_port),     256'(e_wen));
            check("address_port", 256'(address_port), 256'(e_addrp));
            check("wdata_port",   256'(wdata_port),   256'(m_wdata));
            check("wmask_port",   256'(wmask_port),   256'(m_wmask));
            check("rdata_cpu",    256'(rdata_cpu),    256'(m_rdata));
            check("access_fault", 256'(access_fault), 256'(e_fault));
            check("fault_cause",  256'(fault_cause),  256'(e_cause));
            check("fault_addr",   256'(fault_addr),   256'(m_faddr));
            check("txn_count",    256'(txn_count),    256'(e_txn));
        end
    end

    // ---------------- driver ----------------
    int            o_done;
    int            o_en;
    logic [NP-1:0] o_ren;
    logic [NP-1:0] o_wen;
    logic [DW-1:0] o_wd;
    logic [MW-1:0] o_wm;
    logic [DW-1:0] o_rdata;
    logic          o_fault;
    logic [1:0]    o_cause;
    logic [AW-1:0] o_faddr;

    // Cycle 0 is the IDLE cycle that samples the request; vcyc/scyc are the cycles
    // in which the completing and the spurious valid pulses are driven (-1 = none).
    task automatic do_access(input logic r, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                             input int vport, input int vcyc, input logic [DW-1:0] vdata,
                             input int sport, input int scyc);
        o_done = -1; o_en = 0; o_ren = '0; o_wen = '0; o_wd = '0; o_wm = '0;
        o_rdata = '0; o_fault = 1'b0; o_cause = 2'd0; o_faddr = '0;
        @(posedge clk); #1;
        address_cpu = a; wdata_cpu = wd; wmask_cpu = wm; ren_cpu = r; wen_cpu = w;
        for (int cyc = 0; cyc < 64 && o_done < 0; cyc++) begin
            if (cyc > 0) begin
                address_cpu = {$urandom, $urandom};
                wdata_cpu   = {$urandom, $urandom};
                wmask_cpu   = MW'($urandom_range(0, 255));
            end
            rdata_port = {$urandom, $urandom, $urandom, $urandom};
            rdata_port[vport*DW +: DW] = vdata;
            valid_port = '0;
            if (cyc == vcyc) valid_port[vport] = 1'b1;
            if (cyc == scyc) valid_port[sport] = 1'b1;
            @(negedge clk);
            if ((ren_port | wen_port) != '0) begin
                o_en++;
                o_wd = wdata_port;
                o_wm = wmask_port;
            end
            o_ren = o_ren | ren_port;
            o_wen = o_wen | wen_port;
            if (!mem_stall) begin
                o_done  = cyc;
                o_rdata = rdata_cpu;
                o_fault = access_fault;
                o_cause = fault_cause;
                o_faddr = fault_addr;
            end
            @(posedge clk); #1;
        end
        ren_cpu = 1'b0; wen_cpu = 1'b0; valid_port = '0;
        check("access_reaches_done", 256'(o_done >= 0), 256'(1));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_rdata",      256'(rdata_cpu),            256'(0));
        check("rst_txn",        256'(txn_count),            256'(0));
        check("rst_fault_addr", 256'(fault_addr),           256'(0));
        check("rst_enables",    256'(ren_port | wen_port),  256'(0));
        check("rst_fault",      256'(access_fault),         256'(0));
        #2 rstn = 1'b1;

        // Read to port0, valid in the 3rd BUSY cycle.
        do_access(1'b1, 1'b0, 64'h8000_0010, '0, '0, 0, 3, 64'hDEAD_BEEF_0000_0001, 0, -1);
        check("rd0_done_cycle", 256'(o_done),  256'(4));
        check("rd0_ren_seen",   256'(o_ren),   256'(2'b01));
        check("rd0_wen_seen",   256'(o_wen),   256'(2'b00));
        check("rd0_en_cycles",  256'(o_en),    256'(3));
        check("rd0_rdata",      256'(o_rdata), 256'(64'hDEAD_BEEF_0000_0001));
        check("rd0_no_fault",   256'(o_fault), 256'(0));
        check("rd0_txn0",       256'(txn_count[31:0]), 256'(1));

        // Write to port1, valid after one cycle.
        do_access(1'b0, 1'b1, 64'h1000_0008, 64'h55, 8'h01, 1, 1, '0, 0, -1);
        check("wr1_done_cycle", 256'(o_done), 256'(2));
        check("wr1_wen_seen",   256'(o_wen),  256'(2'b10));
        check("wr1_ren_seen",   256'(o_ren),  256'(2'b00));
        check("wr1_wdata",      256'(o_wd),   256'(64'h55));
        check("wr1_wmask",      256'(o_wm),   256'(8'h01));
        check("wr1_txn1",       256'(txn_count[63:32]), 256'(1));
        check("wr1_rdata_kept", 256'(rdata_cpu), 256'(64'hDEAD_BEEF_0000_0001));

        // Port0 read with a stray port1 valid in the middle.
        do_access(1'b1, 1'b0, 64'h8000_0020, '0, '0, 0, 4, 64'h1234_5678_9ABC_DEF0, 1, 2);
        check("spur_done_cycle", 256'(o_done),  256'(5));
        check("spur_rdata",      256'(o_rdata), 256'(64'h1234_5678_9ABC_DEF0));
        check("spur_txn",        256'(txn_count), 256'({32'd1, 32'd2}));

        // Decode miss.
        do_access(1'b1, 1'b0, 64'h0000_4000, '0, '0, 0, -1, '0, 0, -1);
        check("miss_done_cycle", 256'(o_done),  256'(1));
        check("miss_enables",    256'(o_ren | o_wen), 256'(0));
        check("miss_fault",      256'(o_fault), 256'(1));
        check("miss_cause",      256'(o_cause), 256'(1));
        check("miss_faddr",      256'(o_faddr), 256'(64'h4000));
        check("miss_rdata",      256'(o_rdata), 256'(0));

        // ren and wen together.
        do_access(1'b1, 1'b1, 64'h8000_0000, 64'hAA, 8'hFF, 0, -1, '0, 0, -1);
        check("both_done_cycle", 256'(o_done),  256'(1));
        check("both_enables",    256'(o_ren | o_wen), 256'(0));
        check("both_cause",      256'(o_cause), 256'(3));
        check("both_faddr",      256'(o_faddr), 256'(64'h8000_0000));

        // Port1 read that never completes.
        do_access(1'b1, 1'b0, 64'h1000_0100, '0, '0, 1, -1, '0, 0, -1);
        check("to_en_cycles",  256'(o_en),    256'(8));
        check("to_ren_seen",   256'(o_ren),   256'(2'b10));
        check("to_done_cycle", 256'(o_done),  256'(9));
        check("to_cause",      256'(o_cause), 256'(2));
        check("to_faddr",      256'(o_faddr), 256'(64'h1000_0100));
        check("to_rdata",      256'(o_rdata), 256'(0));
        valid_port = 2'b10;
        @(posedge clk); #1;
        valid_port = '0;
        repeat (2) @(posedge clk); #1;
        check("late_valid_txn1", 256'(txn_count[63:32]), 256'(1));

        // Asynchronous reset in the middle of a BUSY access.
        @(posedge clk); #1;
        address_cpu = 64'h8000_0040; ren_cpu = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        check("rst_mid_ren_before", 256'(ren_port), 256'(2'b01));
        rstn = 1'b0;
        #1;
        check("rst_mid_ren_drop",   256'(ren_port),   256'(0));
        check("rst_mid_txn_clear",  256'(txn_count),  256'(0));
        check("rst_mid_faddr",      256'(fault_addr), 256'(0));
        @(posedge clk); #1;
        ren_cpu = 1'b0;
        #2 rstn = 1'b1;
        do_access(1'b1, 1'b0, 64'h8000_0040, '0, '0, 0, 1, 64'hCAFE, 0, -1);
        check("post_rst_done_cycle", 256'(o_done),  256'(2));
        check("post_rst_rdata",      256'(o_rdata), 256'(64'hCAFE));
        check("post_rst_txn",        256'(txn_count), 256'({32'd0, 32'd1}));

        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no finish expected finish before 100000ns");
        $fatal(1);
    end

endmodule
